// File: rtl/fmas_issue.sv
// fmas_issue: issue sequencer for the single-precision FMA pipeline with an in-order result FIFO.
// Optional feature macro FMAS_ISSUE_PERF_EN adds saturating perf_issued/perf_stall counters.
module fmas_issue #(
    parameter int FMA_LAT = 2,
    parameter int DEPTH   = 4,
    parameter int TAGW    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_x,
    input  logic [31:0]     in_y,
    input  logic [31:0]     in_z,
    input  logic [TAGW-1:0] in_tag,
    output logic            fma_req,
    output logic [31:0]     fma_x,
    output logic [31:0]     fma_y,
    output logic [31:0]     fma_z,
    input  logic [31:0]     fma_rslt,
    input  logic [4:0]      fma_flag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_rslt,
    output logic [4:0]      out_flag,
    output logic [TAGW-1:0] out_tag,
    output logic [4:0]      fflags,
    input  logic            fflags_clr,
    output logic            busy
`ifdef FMAS_ISSUE_PERF_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(FMA_LAT + 1);

    function automatic logic [IW-1:0] ones_count(input logic [FMA_LAT-1:0] v);
        logic [IW-1:0] n;
        n = {IW{1'b0}};
        for (int i = 0; i < FMA_LAT; i++) begin
            n = n + IW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    logic                alive_r;
    logic [FMA_LAT-1:0]  vp_r;
    logic [TAGW-1:0]     tp_r [FMA_LAT];
    logic [31:0]         mem_rslt_r [DEPTH];
    logic [4:0]          mem_flag_r [DEPTH];
    logic [TAGW-1:0]     mem_tag_r  [DEPTH];
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;
    logic [4:0]          fflags_r;

    logic [IW-1:0]       inflight_s;
    logic                credit_ok_s;
    logic                wr_s;
    logic                rd_s;
    logic                full_s;
    logic [CW-1:0]       count_nxt_s;
    logic [4:0]          fflags_nxt_s;

    // Credit counts only registered state so in_ready never depends on out_ready.
    assign inflight_s  = ones_count(vp_r);
    assign credit_ok_s = (32'(count_r) + 32'(inflight_s)) < 32'(DEPTH);
    assign in_ready    = alive_r & credit_ok_s;
    assign fma_req     = in_valid & in_ready;
    assign fma_x       = in_x;
    assign fma_y       = in_y;
    assign fma_z       = in_z;

    assign wr_s      = vp_r[FMA_LAT-1];
    assign out_valid = (count_r != {CW{1'b0}});
    assign rd_s      = out_valid & out_ready;
    assign full_s    = (count_r == CW'(DEPTH));
    assign out_rslt  = mem_rslt_r[rd_ptr_r];
    assign out_flag  = mem_flag_r[rd_ptr_r];
    assign out_tag   = mem_tag_r[rd_ptr_r];
    assign fflags    = fflags_r;
    assign busy      = (|vp_r) | out_valid;

    // Next FIFO occupancy and sticky flags; a clear never drops bits retiring this cycle.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_s, rd_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
        if (fflags_clr) begin
            fflags_nxt_s = wr_s ? fma_flag : 5'b00000;
        end else begin
            fflags_nxt_s = fflags_r | (wr_s ? fma_flag : 5'b00000);
        end
    end

    // Acceptance gate and in-flight valid/tag pipes aligned with the FMA latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive_r <= 1'b0;
            vp_r    <= {FMA_LAT{1'b0}};
            for (int i = 0; i < FMA_LAT; i++) begin
                tp_r[i] <= {TAGW{1'b0}};
            end
        end else begin
            alive_r <= 1'b1;
            vp_r[0] <= fma_req;
            tp_r[0] <= in_tag;
            for (int i = 1; i < FMA_LAT; i++) begin
                vp_r[i] <= vp_r[i-1];
                tp_r[i] <= tp_r[i-1];
            end
        end
    end

    // Result FIFO storage, pointers, occupancy and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            fflags_r <= 5'b00000;
            for (int i = 0; i < DEPTH; i++) begin
                mem_rslt_r[i] <= 32'h0000_0000;
                mem_flag_r[i] <= 5'b00000;
                mem_tag_r[i]  <= {TAGW{1'b0}};
            end
        end else begin
            if (wr_s) begin
                mem_rslt_r[wr_ptr_r] <= fma_rslt;
                mem_flag_r[wr_ptr_r] <= fma_flag;
                mem_tag_r[wr_ptr_r]  <= tp_r[FMA_LAT-1];
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r  <= count_nxt_s;
            fflags_r <= fflags_nxt_s;
        end
    end

`ifdef FMAS_ISSUE_PERF_EN
    logic [31:0] perf_issued_r;
    logic [31:0] perf_stall_r;

    assign perf_issued = perf_issued_r;
    assign perf_stall  = perf_stall_r;

    // Saturating issue and back-pressure counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued_r <= 32'h0000_0000;
            perf_stall_r  <= 32'h0000_0000;
        end else begin
            if (fma_req && (perf_issued_r != 32'hFFFF_FFFF)) begin
                perf_issued_r <= perf_issued_r + 32'h0000_0001;
            end else begin
                perf_issued_r <= perf_issued_r;
            end
            if (in_valid && !in_ready && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'h0000_0001;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end
`endif

    fmas_issue_chk u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr_s),
        .rd      (rd_s),
        .full    (full_s)
    );

endmodule

// fmas_issue_chk: protocol assertions for the result FIFO.
module fmas_issue_chk (
    input logic clk,
    input logic reset_n,
    input logic wr,
    input logic rd,
    input logic full
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(wr && full && !rd));

endmodule

// File: doc/fmas_issue.md
Name: fmas_issue

Overview:
- Initiator/sequencer for the single-precision fused multiply-add pipeline.
- Accepts operand triples (x*y+z) with a tag over a valid/ready interface and drives the FMA's req/x/y/z.
- Captures rslt/flag exactly FMA_LAT cycles after each req, queues them in a result FIFO, and returns them in order over a valid/ready interface.
- Keeps sticky accumulated exception flags.

Parameters:
- FMA_LAT, 2, cycles from the FMA req cycle to the cycle its rslt/flag are valid (must be >=1).
- DEPTH, 4, result FIFO entries; also the maximum of in-flight plus queued operations.
- TAGW, 4, tag width carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand triple valid.
- in_ready  out  1  issuer can accept this cycle.
- in_x / in_y / in_z  in  32 each  IEEE-754 single operands.
- in_tag  in  TAGW  user tag.
- fma_req  out  1  request to the FMA pipeline.
- fma_x / fma_y / fma_z  out  32 each  operands to the FMA.
- fma_rslt  in  32  FMA result.
- fma_flag  in  5  FMA flags: [4] NV, [2] OF, [1] UF, [0] NX.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_rslt  out  32  result.
- out_flag  out  5  flags for this result.
- out_tag  out  TAGW  tag of this result.
- fflags  out  5  sticky OR of all retired flags.
- fflags_clr  in  1  clear fflags.
- busy  out  1  any operation in flight or queued.

Behaviour:
- Reset:
  - Asynchronous on reset_n low.
  - in_ready=0 while reset_n=0, and 1 from the first cycle after release (FIFO empty).
  - out_valid=0, fflags=0, busy=0, fma_req=0.
  - In-flight valid pipe, tag pipe, FIFO pointers and count are all cleared.
  - Reset mid-operation discards every in-flight and queued operation; results returning later are ignored.
- Credit rule:
  - in_ready = (fifo_count + inflight_count) < DEPTH.
  - inflight_count is the number of set bits in the FMA_LAT-deep valid pipe.
  - A same-cycle FIFO dequeue is NOT credited; this keeps the path registered-only.
- Issue:
  - fma_req = in_valid & in_ready (combinational).
  - fma_x/y/z = in_x/y/z (pass-through), so the FMA samples them the same cycle.
  - in_valid without in_ready leaves fma_req=0; the operands must be held by the source.
- Tracking:
  - Valid pipe vp[0..FMA_LAT-1] and tag pipe shift every cycle; vp[0] <= fma_req.
  - When vp[FMA_LAT-1]=1, fma_rslt, fma_flag and the aligned tag are written to the FIFO that cycle.
  - Back-to-back issue at one op per cycle is sustained while credit allows.
- FIFO:
  - Circular, DEPTH entries, write/read pointers wrap modulo DEPTH.
  - Overflow is impossible by the credit rule. Assertion: a write never occurs when full unless a read occurs in the same cycle.
  - Simultaneous write and read leaves count unchanged.
  - out_valid = count != 0; out_* are taken from the read-pointer entry.
  - Dequeue on out_valid & out_ready.
  - out_* stay stable while out_valid & ~out_ready.
- Sticky flags:
  - fflags <= (fflags_clr ? 0 : fflags) | (write ? fma_flag : 0).
  - A clear and a new write in the same cycle keep the new bits.
- busy = (inflight_count != 0) | (count != 0).
- Minimum latency from in acceptance to out_valid: FMA_LAT+1 cycles. The FIFO write is registered, so with FMA_LAT=2, accept at cycle N gives out_valid at cycle N+3.

Optional Feature:
- FMAS_ISSUE_PERF_EN defined: adds outputs perf_issued[31:0] and perf_stall[31:0].
  - perf_issued counts fma_req cycles.
  - perf_stall counts cycles with in_valid & ~in_ready.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- x=0x3F800000, y=0x40000000, z=0x40400000, tag=3 -> out_rslt=0x40A00000, flag=0x00, tag=3 at accept+3; fflags=0x00.
- x=0x7F800001 (sNaN), y=0x3F800000, z=0 -> out_rslt=0x7FC00001, flag=0x10; fflags=0x10. Then pulse fflags_clr -> fflags=0x00.
- x=0x7F800000, y=0x00000000, z=0x3F800000 -> out_rslt=0xFFC00000, flag=0x10. Then x=0x7F7FFFFF, y=0x40000000, z=0 -> 0x7F800000, flag=0x05.
- out_ready=0, in_valid=1 continuously with tags 0..7 -> exactly 4 accepted (tags 0-3), then in_ready=0 with fma_req=0. Raise out_ready -> tags 0,1,2,3,4,... emerge in order with none lost or duplicated.
- Issue 2 ops back-to-back, assert reset_n=0 the cycle after the second -> outputs at reset values immediately; after release no out_valid appears even though the FMA returns results.
- Same cycle: fflags_clr=1 with a retiring NX result, prior fflags=0x10 -> fflags=0x01 next cycle.
